mesh_router: RTL and testbench

//  Parametrised 5-port (N,S,E,W,L) wormhole-free mesh router; any mesh position (corner/edge/interior) via PORT_EN mask.
//  Per-input FIFO, XY dimension-order routing, per-output round-robin arbitration, credit-based flow control.

---
 rtl/noc_pkg.sv | 35 +++
 rtl/router_in_fifo.sv | 53 +++++
 rtl/mesh_router.sv | 184 ++++++++++++++++++
 tb/tb_mesh_router.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// noc_pkg: port indices, port vector type, route-direction enum and the XY route helper
// shared by the mesh router and its input FIFOs.
package noc_pkg;

  localparam int NPORTS = 5;
  localparam int P_N    = 0;
  localparam int P_S    = 1;
  localparam int P_E    = 2;
  localparam int P_W    = 3;
  localparam int P_L    = 4;

  typedef logic [NPORTS-1:0] port_vec_t;

  // Encodings equal the port indices so a direction can index port vectors directly.
  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_S = 3'd1,
    DIR_E = 3'd2,
    DIR_W = 3'd3,
    DIR_L = 3'd4
  } route_dir_t;

  // Dimension-order routing: settle X first, then Y, else deliver locally.
  function automatic route_dir_t xy_route(input logic [15:0] dx, input logic [15:0] dy,
                                          input logic [15:0] x,  input logic [15:0] y);
    route_dir_t dir;
    if (dx > x)      dir = DIR_E;
    else if (dx < x) dir = DIR_W;
    else if (dy > y) dir = DIR_S;
    else if (dy < y) dir = DIR_N;
    else             dir = DIR_L;
    return dir;
  endfunction

endpackage

// File: rtl/router_in_fifo.sv
// router_in_fifo: per-port flit buffer with a show-ahead head word.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module router_in_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mesh_router.sv
// mesh_router: 5-port XY mesh router with input FIFOs, per-output round-robin and credit flow control.
// Define ROUTER_STATS_EN to add the per-output flit_cnt_o counters.
module mesh_router
  import noc_pkg::*;
#(
  parameter int         XCOORD  = 4,
  parameter int         YCOORD  = 4,
  parameter int         DATA_W  = 16,
  parameter int         COORD_W = 4,
  parameter int         DEPTH   = 4,
  parameter int         CREDITS = 4,
  parameter logic [4:0] PORT_EN = 5'b11111
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORTS-1:0]        valid_i,
  input  logic [NPORTS*DATA_W-1:0] data_i,
  output logic [NPORTS-1:0]        credit_o,
  output logic [NPORTS-1:0]        enable_o,
  output logic [NPORTS*DATA_W-1:0] data_o,
  input  logic [NPORTS-1:0]        credit_i,
`ifdef ROUTER_STATS_EN
  output logic [NPORTS*16-1:0]     flit_cnt_o,
`endif
  output logic                     err_o
);

  localparam int            CW         = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS);

  logic [NPORTS-1:0][DATA_W-1:0] din;
  logic [NPORTS-1:0][DATA_W-1:0] head;
  logic [NPORTS-1:0][DATA_W-1:0] data_reg;
  port_vec_t                     fifo_full;
  port_vec_t                     fifo_empty;
  port_vec_t                     pop;
  port_vec_t                     discard;
  port_vec_t                     overflow;
  port_vec_t                     credit_ovf;
  port_vec_t                     gnt_any;
  port_vec_t                     enable_reg;
  port_vec_t                     credit_out_reg;
  route_dir_t                    dir [NPORTS];
  port_vec_t                     req [NPORTS];
  logic [NPORTS-1:0][2:0]        gnt_idx;
  logic [NPORTS-1:0][2:0]        ptr_reg;
  logic [NPORTS-1:0][2:0]        ptr_next;
  logic [NPORTS-1:0][CW-1:0]     credit_reg;
  logic [NPORTS-1:0][CW-1:0]     credit_next;
  logic                          err_reg;

  assign din = data_i;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_in
      if (PORT_EN[gi]) begin : g_fifo
        router_in_fifo #(
          .DATA_W (DATA_W),
          .DEPTH  (DEPTH)
        ) u_fifo (
          .clk   (clk),
          .rst   (rst),
          .push  (valid_i[gi]),
          .pop   (pop[gi]),
          .din   (din[gi]),
          .full  (fifo_full[gi]),
          .empty (fifo_empty[gi]),
          .head  (head[gi])
        );
      end else begin : g_tie
        // Absent port: inputs are ignored and the buffer looks permanently empty.
        logic tie_unused;
        assign tie_unused     = ^{valid_i[gi], din[gi]};
        assign fifo_full[gi]  = 1'b0;
        assign fifo_empty[gi] = 1'b1;
        assign head[gi]       = '0;
      end
    end
  endgenerate

  // Route every head, build per-output request vectors, then pick a round-robin winner.
  always_comb begin
    int   idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    discard = '0;
    pop     = '0;
    gnt_any = '0;
    gnt_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      dir[i] = xy_route(16'(head[i][2*COORD_W-1:COORD_W]), 16'(head[i][COORD_W-1:0]),
                        16'(XCOORD), 16'(YCOORD));
      discard[i] = !fifo_empty[i] && !PORT_EN[dir[i]];
    end
    for (int o = 0; o < NPORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NPORTS; i++) begin
        req[o][i] = !fifo_empty[i] && (dir[i] == route_dir_t'(o)) && PORT_EN[o];
      end
      found = 1'b0;
      if (credit_reg[o] != '0) begin
        for (int k = 0; k < NPORTS; k++) begin
          idx = int'(ptr_reg[o]) + k;
          if (idx >= NPORTS) idx = idx - NPORTS;
          if (!found && req[o][idx]) begin
            found      = 1'b1;
            gnt_idx[o] = 3'(idx);
          end
        end
      end
      gnt_any[o] = found;
    end
    pop = discard;
    for (int o = 0; o < NPORTS; o++) begin
      if (gnt_any[o]) pop[gnt_idx[o]] = 1'b1;
    end
  end

  always_comb begin
    logic ret;
    ret         = 1'b0;
    ptr_next    = ptr_reg;
    credit_next = credit_reg;
    credit_ovf  = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (gnt_any[o]) begin
        ptr_next[o] = (gnt_idx[o] == 3'(NPORTS - 1)) ? 3'd0 : gnt_idx[o] + 3'd1;
      end
      ret = credit_i[o] && PORT_EN[o];
      // A send and a return in the same cycle cancel out.
      if (gnt_any[o] && !ret) begin
        credit_next[o] = credit_reg[o] - 1'b1;
      end else if (ret && !gnt_any[o]) begin
        if (credit_reg[o] == CREDIT_MAX) credit_ovf[o] = 1'b1;
        else                             credit_next[o] = credit_reg[o] + 1'b1;
      end
    end
  end

  assign overflow = valid_i & port_vec_t'(PORT_EN) & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      enable_reg     <= '0;
      data_reg       <= '0;
      credit_out_reg <= '0;
      ptr_reg        <= '0;
      err_reg        <= 1'b0;
      for (int o = 0; o < NPORTS; o++) credit_reg[o] <= CREDIT_MAX;
    end else begin
      enable_reg     <= gnt_any;
      credit_out_reg <= pop;
      ptr_reg        <= ptr_next;
      credit_reg     <= credit_next;
      for (int o = 0; o < NPORTS; o++) begin
        if (gnt_any[o]) data_reg[o] <= head[gnt_idx[o]];
      end
      if ((|overflow) || (|credit_ovf) || (|discard)) err_reg <= 1'b1;
    end
  end

  assign enable_o = enable_reg;
  assign data_o   = data_reg;
  assign credit_o = credit_out_reg;
  assign err_o    = err_reg;

`ifdef ROUTER_STATS_EN
  logic [NPORTS-1:0][15:0] flit_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      flit_cnt_reg <= '0;
    end else begin
      for (int o = 0; o < NPORTS; o++) begin
        if (enable_reg[o]) flit_cnt_reg[o] <= flit_cnt_reg[o] + 16'd1;
      end
    end
  end

  assign flit_cnt_o = flit_cnt_reg;
`endif

endmodule

// File: tb/tb_mesh_router.sv
// tb_mesh_router: directed vector table plus hand-written multi-cycle sequences for mesh_router
// placed at (1,1); a second instance covers a north-west corner port mask.
module tb_mesh_router;

  localparam int DW  = 16;
  localparam int PN  = 0;
  localparam int PS  = 1;
  localparam int PE  = 2;
  localparam int PW  = 3;
  localparam int PL  = 4;

  typedef struct {
    logic [2:0]    in_port;
    logic [DW-1:0] flit;
    logic [2:0]    out_port;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    valid_i, credit_i, credit_o, enable_o;
  logic [5*DW-1:0] data_i, data_o;
  logic          err_o;
  logic [4:0]    valid_c, credit_in_c, credit_out_c, en_c;
  logic [5*DW-1:0] data_c, dout_c;
  logic          err_c;
`ifdef ROUTER_STATS_EN
  logic [79:0]   flit_cnt, flit_cnt_c;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int sent;
  vec_t vecs [10];

  always #5 clk = ~clk;

  mesh_router #(.XCOORD(1), .YCOORD(1), .DATA_W(DW), .COORD_W(4), .DEPTH(4), .CREDITS(4),
                .PORT_EN(5'b11111)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_i(data_i), .credit_o(credit_o),
    .enable_o(enable_o), .data_o(data_o), .credit_i(credit_i),
`ifdef ROUTER_STATS_EN
    .flit_cnt_o(flit_cnt),
`endif
    .err_o(err_o));

  mesh_router #(.XCOORD(1), .YCOORD(1), .DATA_W(DW), .COORD_W(4), .DEPTH(4), .CREDITS(4),
                .PORT_EN(5'b10110)) dut_c (
    .clk(clk), .rst(rst), .valid_i(valid_c), .data_i(data_c), .credit_o(credit_out_c),
    .enable_o(en_c), .data_o(dout_c), .credit_i(credit_in_c),
`ifdef ROUTER_STATS_EN
    .flit_cnt_o(flit_cnt_c),
`endif
    .err_o(err_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    valid_i     = '0;
    credit_i    = '0;
    valid_c     = '0;
    credit_in_c = '0;
    step();
    rst = 1'b1;
  endtask

  // Drive nflits back-to-back flits (dest X=3,Y=1 -> east) on one port, counting east outputs.
  task automatic inject_count(input int port, input int nflits, input int cycles, output int cnt);
    cnt = 0;
    for (int c = 0; c < cycles; c++) begin
      if (enable_o[PE]) cnt++;
      valid_i = '0;
      if (c < nflits) begin
        valid_i[port]          = 1'b1;
        data_i[port*DW +: DW]  = {8'(c), 8'h31};
      end
      step();
    end
    valid_i = '0;
  endtask

  initial begin
    vecs[0] = '{3'd4, 16'h0031, 3'd2};
    vecs[1] = '{3'd4, 16'h0101, 3'd3};
    vecs[2] = '{3'd4, 16'h0212, 3'd1};
    vecs[3] = '{3'd4, 16'h0310, 3'd0};
    vecs[4] = '{3'd4, 16'h0411, 3'd4};
    vecs[5] = '{3'd0, 16'h0521, 3'd2};
    vecs[6] = '{3'd2, 16'h0631, 3'd2};
    vecs[7] = '{3'd3, 16'h0715, 3'd1};
    vecs[8] = '{3'd1, 16'h0801, 3'd3};
    vecs[9] = '{3'd2, 16'h0911, 3'd4};

    data_i = '0;
    data_c = '0;
    rst    = 1'b0;
    valid_i = '0; credit_i = '0; valid_c = '0; credit_in_c = '0;
    step();
    step();
    check("rst_enable", 80'(enable_o), 80'(0));
    check("rst_data", 80'(data_o), 80'(0));
    check("rst_credit_o", 80'(credit_o), 80'(0));
    check("rst_err", 80'(err_o), 80'(0));
    rst = 1'b1;
    step();

    // Single flits in isolation: two-cycle latency, credit back upstream, credit returned downstream.
    for (int v = 0; v < 10; v++) begin
      $display("[TB] vec %0d: in=%0d flit=%h -> out=%0d", v, vecs[v].in_port, vecs[v].flit,
               vecs[v].out_port);
      valid_i = 5'b1 << vecs[v].in_port;
      data_i[vecs[v].in_port*DW +: DW] = vecs[v].flit;
      step();
      valid_i = '0;
      check("vec_early_enable", 80'(enable_o), 80'(0));
      step();
      check("vec_enable", 80'(enable_o), 80'(5'b1 << vecs[v].out_port));
      check("vec_data", 80'(data_o[vecs[v].out_port*DW +: DW]), 80'(vecs[v].flit));
      check("vec_credit_o", 80'(credit_o), 80'(5'b1 << vecs[v].in_port));
      credit_i = 5'b1 << vecs[v].out_port;
      step();
      credit_i = '0;
    end
    check("vec_err", 80'(err_o), 80'(0));

    // N, S, W contend for E from a fresh pointer: served N, S, W.
    do_reset();
    valid_i = 5'b01011;
    data_i[PN*DW +: DW] = 16'hA051;
    data_i[PS*DW +: DW] = 16'hB051;
    data_i[PW*DW +: DW] = 16'hC051;
    step();
    valid_i = '0;
    step();
    $display("[TB] rr: N,S,W -> E");
    check("rr_en0", 80'(enable_o), 80'(5'b00100));
    check("rr_data0", 80'(data_o[PE*DW +: DW]), 80'(16'hA051));
    check("rr_cred0", 80'(credit_o), 80'(5'b00001));
    step();
    check("rr_en1", 80'(enable_o), 80'(5'b00100));
    check("rr_data1", 80'(data_o[PE*DW +: DW]), 80'(16'hB051));
    check("rr_cred1", 80'(credit_o), 80'(5'b00010));
    step();
    check("rr_en2", 80'(enable_o), 80'(5'b00100));
    check("rr_data2", 80'(data_o[PE*DW +: DW]), 80'(16'hC051));
    check("rr_cred2", 80'(credit_o), 80'(5'b01000));
    step();
    check("rr_idle", 80'(enable_o), 80'(0));
`ifdef ROUTER_STATS_EN
    check("stats_E", 80'(flit_cnt[PE*16 +: 16]), 80'(3));
`endif
    credit_i = 5'b00100;
    step(); step(); step();
    credit_i = '0;
    // Pointer now sits past W, so L beats N.
    valid_i = 5'b10001;
    data_i[PN*DW +: DW] = 16'hD051;
    data_i[PL*DW +: DW] = 16'hE051;
    step();
    valid_i = '0;
    step();
    $display("[TB] rr: N,L -> E after rotation");
    check("rot_data0", 80'(data_o[PE*DW +: DW]), 80'(16'hE051));
    check("rot_cred0", 80'(credit_o), 80'(5'b10000));
    step();
    check("rot_data1", 80'(data_o[PE*DW +: DW]), 80'(16'hD051));
    check("rot_cred1", 80'(credit_o), 80'(5'b00001));
    check("rr_err", 80'(err_o), 80'(0));

    // Six flits to E with four credits: four go, then one credit releases the fifth.
    do_reset();
    inject_count(PL, 6, 14, sent);
    $display("[TB] credit stall: %0d flits sent of 6", sent);
    check("credit_limit", 80'(sent), 80'(4));
    credit_i = 5'b00100;
    step();
    credit_i = '0;
    check("credit_wait", 80'(enable_o), 80'(0));
    step();
    check("credit_fifth_en", 80'(enable_o), 80'(5'b00100));
    check("credit_fifth_data", 80'(data_o[PE*DW +: DW]), 80'(16'h0431));
    step();
    check("credit_exhausted", 80'(enable_o), 80'(0));
    check("credit_err", 80'(err_o), 80'(0));

    // Drain E credits, then overfill a stalled L FIFO.
    do_reset();
    inject_count(PW, 4, 8, sent);
    check("drain_sent", 80'(sent), 80'(4));
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check("ovf_before", 80'(err_o), 80'(0));
      valid_i = 5'b10000;
      data_i[PL*DW +: DW] = {8'(8'h40 + i), 8'h31};
      step();
    end
    valid_i = '0;
    $display("[TB] overflow: 5 writes into depth-4 FIFO");
    check("ovf_err", 80'(err_o), 80'(1));
    // A credit arrives and a grant is pending when reset hits.
    credit_i = 5'b00100;
    step();
    credit_i = '0;
    rst = 1'b0;
    step();
    check("midrst_enable", 80'(enable_o), 80'(0));
    check("midrst_data", 80'(data_o), 80'(0));
    check("midrst_credit_o", 80'(credit_o), 80'(0));
    check("midrst_err", 80'(err_o), 80'(0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_flushed", 80'(enable_o), 80'(0));
    end
    inject_count(PN, 5, 12, sent);
    $display("[TB] after reset: %0d flits sent of 5", sent);
    check("credit_reload", 80'(sent), 80'(4));

    // Corner router: absent N input ignored, westbound flit discarded.
    do_reset();
    valid_c = 5'b00001;
    data_c[PN*DW +: DW] = 16'h0031;
    step();
    valid_c = '0;
    step();
    step();
    check("absent_in_en", 80'(en_c), 80'(0));
    check("absent_in_cred", 80'(credit_out_c), 80'(0));
    check("absent_in_err", 80'(err_c), 80'(0));
    valid_c = 5'b10000;
    data_c[PL*DW +: DW] = 16'h0001;
    step();
    valid_c = '0;
    step();
    $display("[TB] corner: L flit to absent W discarded");
    check("corner_cred", 80'(credit_out_c), 80'(5'b10000));
    check("corner_err", 80'(err_c), 80'(1));
    check("corner_en", 80'(en_c), 80'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
